timer0_ctrl: RTL and testbench

Sequencing controller for the Timer 0 datapath registers TL0 and TH0. It derives machine-cycle ticks or external T0 events, applies the TMOD-selected mode (0–3) arithmetic to the current TL0/TH0 values, and issues single-cycle write strobes with new byte values to the TL0/TH0 register blocks. It raises TF0 (and TF1 in mode 3) set pulses toward TCON. CPU SFR writes to TL0/TH0 take priority over timer updates.

---
 rtl/timer0_ctrl.sv | 129 ++++++++++++
 tb/tb_timer0_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer0_ctrl.sv
// timer0_ctrl: Timer 0 sequencer. Turns machine-cycle ticks or T0 pin edges into TL0/TH0
// write strobes with next byte values and TF0/TF1 set pulses; CPU SFR writes take priority.
module timer0_ctrl #(
  parameter int unsigned PRESCALE = 12,
  parameter int unsigned PS_W     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_tmod,
  input  logic       i_tr0,
  input  logic       i_tr1,
  input  logic       i_int0_n,
  input  logic       i_t0,
  input  logic [7:0] i_tl0,
  input  logic [7:0] i_th0,
  input  logic       i_cpu_wr_tl0,
  input  logic       i_cpu_wr_th0,
  output logic       o_tl0_wr,
  output logic [7:0] o_tl0_byte,
  output logic       o_th0_wr,
  output logic [7:0] o_th0_byte,
  output logic       o_tf0_set,
  output logic       o_tf1_set
);

  typedef enum logic [1:0] {
    MODE_13BIT  = 2'd0,
    MODE_16BIT  = 2'd1,
    MODE_RELOAD = 2'd2,
    MODE_SPLIT  = 2'd3
  } mode_e;

  logic            gate;
  logic            ct;
  mode_e           mode;
  logic [PS_W-1:0] ps;
  logic            mc_wrap;
  logic            t0_s1, t0_s2;
  logic            int0_s1, int0_s2;
  logic            t0_prev;
  logic            tick_q;
  logic            tick_hi_q;
  logic            run_lo;
  logic            lo_event;
  logic            cpu_any;
  logic [12:0]     cnt13;
  logic [15:0]     cnt16;

  assign gate    = i_tmod[3];
  assign ct      = i_tmod[2];
  assign mode    = mode_e'(i_tmod[1:0]);
  assign mc_wrap = (ps == PS_W'(PRESCALE - 1));
  assign run_lo  = i_tr0 & (~gate | int0_s2);
  // Counter mode: a falling edge is a 1->0 between consecutive machine-cycle samples.
  assign lo_event = ct ? (mc_wrap & t0_prev & ~t0_s2) : mc_wrap;
  assign cpu_any  = i_cpu_wr_tl0 | i_cpu_wr_th0;
  assign cnt13    = {i_th0, i_tl0[4:0]} + 13'd1;
  assign cnt16    = {i_th0, i_tl0} + 16'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps        <= '0;
      t0_s1     <= 1'b1;
      t0_s2     <= 1'b1;
      int0_s1   <= 1'b1;
      int0_s2   <= 1'b1;
      t0_prev   <= 1'b1;
      tick_q    <= 1'b0;
      tick_hi_q <= 1'b0;
    end else begin
      t0_s1     <= i_t0;
      t0_s2     <= t0_s1;
      int0_s1   <= i_int0_n;
      int0_s2   <= int0_s1;
      ps        <= mc_wrap ? '0 : ps + PS_W'(1);
      if (mc_wrap) t0_prev <= t0_s2;
      tick_q    <= lo_event & run_lo;
      tick_hi_q <= mc_wrap & i_tr1;
    end
  end

  always_comb begin
    o_tl0_wr   = 1'b0;
    o_th0_wr   = 1'b0;
    o_tf0_set  = 1'b0;
    o_tf1_set  = 1'b0;
    o_tl0_byte = i_tl0 + 8'd1;
    o_th0_byte = i_th0 + 8'd1;
    case (mode)
      MODE_13BIT: begin
        o_tl0_byte = {i_tl0[7:5], cnt13[4:0]};
        o_th0_byte = cnt13[12:5];
        if (tick_q && !cpu_any) begin
          o_tl0_wr  = 1'b1;
          o_th0_wr  = 1'b1;
          o_tf0_set = &{i_th0, i_tl0[4:0]};
        end
      end
      MODE_16BIT: begin
        o_tl0_byte = cnt16[7:0];
        o_th0_byte = cnt16[15:8];
        if (tick_q && !cpu_any) begin
          o_tl0_wr  = 1'b1;
          o_th0_wr  = 1'b1;
          o_tf0_set = &{i_th0, i_tl0};
        end
      end
      MODE_RELOAD: begin
        o_tl0_byte = (&i_tl0) ? i_th0 : i_tl0 + 8'd1;
        if (tick_q && !i_cpu_wr_tl0) begin
          o_tl0_wr  = 1'b1;
          o_tf0_set = &i_tl0;
        end
      end
      MODE_SPLIT: begin
        // Halves update independently; a CPU write only blocks its own half.
        if (tick_q && !i_cpu_wr_tl0) begin
          o_tl0_wr  = 1'b1;
          o_tf0_set = &i_tl0;
        end
        if (tick_hi_q && !i_cpu_wr_th0) begin
          o_th0_wr  = 1'b1;
          o_tf1_set = &i_th0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_timer0_ctrl.sv
// Self-checking bench for timer0_ctrl: models the TL0/TH0 register blocks and
// checks strobes/pulses against a queue of expected update events.
module tb_timer0_ctrl;
  localparam int PRESCALE = 12;

  typedef logic [19:0] exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tmod = 4'b0001;
  logic       tr0 = 1'b0;
  logic       tr1 = 1'b0;
  logic       int0_n = 1'b1;
  logic       t0 = 1'b1;
  logic [7:0] tl0 = 8'h00;
  logic [7:0] th0 = 8'h00;
  logic       cpu_wr_tl0 = 1'b0;
  logic       cpu_wr_th0 = 1'b0;
  logic [7:0] cpu_tl = 8'h00;
  logic [7:0] cpu_th = 8'h00;
  logic       tl0_wr, th0_wr, tf0_set, tf1_set;
  logic [7:0] tl0_byte, th0_byte;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  timer0_ctrl #(.PRESCALE(PRESCALE), .PS_W(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tmod      (tmod),
    .i_tr0       (tr0),
    .i_tr1       (tr1),
    .i_int0_n    (int0_n),
    .i_t0        (t0),
    .i_tl0       (tl0),
    .i_th0       (th0),
    .i_cpu_wr_tl0(cpu_wr_tl0),
    .i_cpu_wr_th0(cpu_wr_th0),
    .o_tl0_wr    (tl0_wr),
    .o_tl0_byte  (tl0_byte),
    .o_th0_wr    (th0_wr),
    .o_th0_byte  (th0_byte),
    .o_tf0_set   (tf0_set),
    .o_tf1_set   (tf1_set)
  );

  // TL0/TH0 register blocks: CPU write wins over a timer strobe.
  always @(posedge clk) begin
    if (cpu_wr_tl0) tl0 <= cpu_tl;
    else if (tl0_wr) tl0 <= tl0_byte;
    if (cpu_wr_th0) th0 <= cpu_th;
    else if (th0_wr) th0 <= th0_byte;
  end

  function automatic exp_t mk(input logic tlw, input logic [7:0] tl, input logic thw,
                              input logic [7:0] th, input logic f0, input logic f1);
    return {tlw, tl, thw, th, f0, f1};
  endfunction

  function automatic exp_t observe();
    return {tl0_wr, tl0_wr ? tl0_byte : 8'h00, th0_wr, th0_wr ? th0_byte : 8'h00, tf0_set, tf1_set};
  endfunction

  function automatic logic any_out();
    return tl0_wr | th0_wr | tf0_set | tf1_set;
  endfunction

  task automatic wait_event(input int budget, output logic seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (any_out()) seen = 1'b1;
    end
  endtask

  task automatic preset(input logic [7:0] tl, input logic [7:0] th);
    @(negedge clk);
    cpu_wr_tl0 = 1'b1;
    cpu_wr_th0 = 1'b1;
    cpu_tl = tl;
    cpu_th = th;
    @(negedge clk);
    cpu_wr_tl0 = 1'b0;
    cpu_wr_th0 = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({tl0_wr, th0_wr, tf0_set, tf1_set} !== 4'b0000)
      $display("FAIL reset_outputs got %b want 0000", {tl0_wr, th0_wr, tf0_set, tf1_set});
    else passed++;
    rst_n = 1'b1;
    n = 0;
    repeat (3 * PRESCALE) begin
      @(negedge clk);
      if (any_out()) n++;
    end
    total++;
    if (n != 0) $display("FAIL reset_idle got %0d strobes want 0", n);
    else passed++;
  endtask

  task automatic test_mode1();
    exp_t e; logic seen; int cyc; int n;
    tmod = 4'b0001;
    preset(8'hFE, 8'hFF);
    sb.push_back(mk(1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0));
    tr0 = 1'b1;
    wait_event(3 * PRESCALE, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL m1_first timeout want %h", e);
    else if (observe() !== e) $display("FAIL m1_first got %h want %h", observe(), e);
    else passed++;
    wait_event(PRESCALE + 4, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL m1_wrap timeout want %h", e);
    else if (observe() !== e) $display("FAIL m1_wrap got %h want %h", observe(), e);
    else passed++;
    total++;
    if (cyc != PRESCALE) $display("FAIL m1_spacing got %0d want %0d", cyc, PRESCALE);
    else passed++;
    tr0 = 1'b0;
    @(negedge clk);
    total++;
    if ({th0, tl0} !== 16'h0000) $display("FAIL m1_regs got %h want 0000", {th0, tl0});
    else passed++;
    n = 0;
    repeat (3 * PRESCALE) begin
      @(negedge clk);
      if (any_out()) n++;
    end
    total++;
    if (n != 0) $display("FAIL m1_tr0_off got %0d strobes want 0", n);
    else passed++;
  endtask

  task automatic test_mode2();
    exp_t e; logic seen; int cyc;
    tmod = 4'b0010;
    preset(8'hFF, 8'h9C);
    sb.push_back(mk(1'b1, 8'h9C, 1'b0, 8'h00, 1'b1, 1'b0));
    sb.push_back(mk(1'b1, 8'h9D, 1'b0, 8'h00, 1'b0, 1'b0));
    tr0 = 1'b1;
    wait_event(3 * PRESCALE, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL m2_reload timeout want %h", e);
    else if (observe() !== e) $display("FAIL m2_reload got %h want %h", observe(), e);
    else passed++;
    wait_event(PRESCALE + 4, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL m2_next timeout want %h", e);
    else if (observe() !== e) $display("FAIL m2_next got %h want %h", observe(), e);
    else passed++;
    tr0 = 1'b0;
    @(negedge clk);
    total++;
    if ({th0, tl0} !== 16'h9C9D) $display("FAIL m2_regs got %h want 9c9d", {th0, tl0});
    else passed++;
  endtask

  task automatic test_mode0();
    exp_t e; logic seen; int cyc;
    tmod = 4'b0000;
    preset(8'hFF, 8'hFF);
    sb.push_back(mk(1'b1, 8'hE0, 1'b1, 8'h00, 1'b1, 1'b0));
    sb.push_back(mk(1'b1, 8'hE1, 1'b1, 8'h00, 1'b0, 1'b0));
    tr0 = 1'b1;
    wait_event(3 * PRESCALE, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL m0_wrap timeout want %h", e);
    else if (observe() !== e) $display("FAIL m0_wrap got %h want %h", observe(), e);
    else passed++;
    wait_event(PRESCALE + 4, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL m0_next timeout want %h", e);
    else if (observe() !== e) $display("FAIL m0_next got %h want %h", observe(), e);
    else passed++;
    tr0 = 1'b0;
    @(negedge clk);
    total++;
    if ({th0, tl0} !== 16'h00E1) $display("FAIL m0_regs got %h want 00e1", {th0, tl0});
    else passed++;
  endtask

  task automatic test_counter();
    exp_t e; int n;
    tmod = 4'b0101;
    t0 = 1'b1;
    preset(8'h00, 8'h00);
    for (int k = 1; k <= 4; k++) sb.push_back(mk(1'b1, 8'(k), 1'b1, 8'h00, 1'b0, 1'b0));
    tr0 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      t0 = ((c / (2 * PRESCALE)) % 2) == 0;
      if (any_out()) begin
        total++;
        if (sb.size() == 0) $display("FAIL ctr_extra got %h want none", observe());
        else begin
          e = sb.pop_front();
          if (observe() !== e) $display("FAIL ctr_edge got %h want %h", observe(), e);
          else passed++;
        end
      end
    end
    tr0 = 1'b0;
    total++;
    if (sb.size() != 0) $display("FAIL ctr_missing got %0d pending want 0", sb.size());
    else passed++;
    sb.delete();
    tmod = 4'b1101;
    int0_n = 1'b0;
    repeat (4) @(negedge clk);
    tr0 = 1'b1;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      t0 = ((c / (2 * PRESCALE)) % 2) == 0;
      if (any_out()) n++;
    end
    tr0 = 1'b0;
    int0_n = 1'b1;
    total++;
    if (n != 0) $display("FAIL ctr_gated got %0d strobes want 0", n);
    else passed++;
  endtask

  task automatic test_mode3();
    exp_t e; logic seen; int cyc;
    tmod = 4'b0011;
    preset(8'h55, 8'hFF);
    sb.push_back(mk(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1));
    sb.push_back(mk(1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0));
    tr1 = 1'b1;
    wait_event(3 * PRESCALE, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL m3_th_wrap timeout want %h", e);
    else if (observe() !== e) $display("FAIL m3_th_wrap got %h want %h", observe(), e);
    else passed++;
    wait_event(PRESCALE + 4, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL m3_th_next timeout want %h", e);
    else if (observe() !== e) $display("FAIL m3_th_next got %h want %h", observe(), e);
    else passed++;
    tr1 = 1'b0;
    @(negedge clk);
    total++;
    if ({th0, tl0} !== 16'h0155) $display("FAIL m3_regs got %h want 0155", {th0, tl0});
    else passed++;
    preset(8'hFF, 8'h7F);
    sb.push_back(mk(1'b1, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0));
    tr0 = 1'b1;
    tr1 = 1'b1;
    wait_event(3 * PRESCALE, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL m3_both timeout want %h", e);
    else if (observe() !== e) $display("FAIL m3_both got %h want %h", observe(), e);
    else passed++;
    tr0 = 1'b0;
    tr1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_collision();
    exp_t e; logic seen; int cyc; int n;
    tmod = 4'b0001;
    preset(8'hFE, 8'hFF);
    sb.push_back(mk(1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0));
    tr0 = 1'b1;
    wait_event(3 * PRESCALE, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL col_setup timeout want %h", e);
    else if (observe() !== e) $display("FAIL col_setup got %h want %h", observe(), e);
    else passed++;
    n = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == PRESCALE - 1) begin
        cpu_wr_tl0 = 1'b1;
        cpu_tl = 8'hFF;
      end
      if (i == PRESCALE + 1) cpu_wr_tl0 = 1'b0;
      if (any_out()) n++;
    end
    total++;
    if (n != 0) $display("FAIL col_drop got %0d strobes want 0", n);
    else passed++;
    sb.push_back(mk(1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0));
    wait_event(2 * PRESCALE, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL col_next timeout want %h", e);
    else if (observe() !== e) $display("FAIL col_next got %h want %h", observe(), e);
    else passed++;
    total++;
    if (cyc != 2 * PRESCALE - 18) $display("FAIL col_no_retry got %0d want %0d", cyc, 2 * PRESCALE - 18);
    else passed++;
    tr0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e; logic seen; int cyc;
    tmod = 4'b0001;
    preset(8'h00, 8'h00);
    sb.push_back(mk(1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 1'b0));
    tr0 = 1'b1;
    wait_event(3 * PRESCALE, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL rst_pre timeout want %h", e);
    else if (observe() !== e) $display("FAIL rst_pre got %h want %h", observe(), e);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({tl0_wr, th0_wr, tf0_set, tf1_set} !== 4'b0000)
      $display("FAIL rst_async got %b want 0000", {tl0_wr, th0_wr, tf0_set, tf1_set});
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 1'b0));
    wait_event(3 * PRESCALE, seen, cyc);
    e = sb.pop_front();
    total++;
    if (!seen) $display("FAIL rst_post timeout want %h", e);
    else if (observe() !== e) $display("FAIL rst_post got %h want %h", observe(), e);
    else passed++;
    total++;
    if (cyc != PRESCALE) $display("FAIL rst_latency got %0d want %0d", cyc, PRESCALE);
    else passed++;
    tr0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mode1();
    test_mode2();
    test_mode0();
    test_counter();
    test_mode3();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
